ahb_apb4_bridge: RTL and testbench

AHB_APB4_BRIDGE -- requirements
Module: ahb_apb4_bridge

---
 rtl/ahb_apb_pkg.sv | 31 +++
 rtl/ahb_apb4_strb.sv | 22 ++
 rtl/ahb_apb4_bridge.sv | 174 +++++++++++++++++
 tb/tb_ahb_apb4_bridge.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared definitions for the AHB-lite to APB4 bridge: FSM encoding and
// AHB protocol codes.
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // AHB HPROT -> APB PPROT: {instruction, non-secure, privileged}
  function automatic logic [2:0] apb_prot(input logic [3:0] hprot);
    return {~hprot[0], 1'b1, hprot[1]};
  endfunction

endpackage

// File: rtl/ahb_apb4_strb.sv
// Byte-lane strobe generation for APB4 writes; reads always drive zero.
module ahb_apb4_strb
  import ahb_apb_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] haddr_i,
  input  logic       hwrite_i,
  output logic [3:0] pstrb_o
);

  always_comb begin
    pstrb_o = 4'b0000;
    if (hwrite_i) begin
      case (hsize_i)
        HSIZE_BYTE: pstrb_o = 4'b0001 << haddr_i;
        HSIZE_HALF: pstrb_o = haddr_i[1] ? 4'b1100 : 4'b0011;
        default:    pstrb_o = 4'b1111;
      endcase
    end
  end

endmodule

// File: rtl/ahb_apb4_bridge.sv
// AHB-lite slave to multi-slave APB4 bridge with PCLKEN-qualified APB timing,
// optional ACCESS timeout and two-cycle AHB ERROR response.
module ahb_apb4_bridge
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SLV_LSB = 12,
  parameter int TIMEOUT = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_W-1:0]     HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [3:0]            HPROT,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  input  logic                  PCLKEN,
  output logic [NUM_SLV-1:0]    PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_W-1:0]     PADDR,
  output logic [31:0]           PWDATA,
  output logic [3:0]            PSTRB,
  output logic [2:0]            PPROT,
  input  logic [NUM_SLV-1:0]    PREADY,
  input  logic [NUM_SLV-1:0]    PSLVERR,
  input  logic [NUM_SLV*32-1:0] PRDATA
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W:0]   SLV_CNT = (IDX_W + 1)'(NUM_SLV);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_in;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                hreadyout_q, hreadyout_d;
  logic                hresp_q, hresp_d;
  logic [NUM_SLV-1:0]  psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [31:0]         pwdata_q, hrdata_q;
  logic [3:0]          pstrb_q, strb_in;
  logic [2:0]          pprot_q;
  logic                xfer, idx_ok, sel_on;
  logic                pready_s, pslverr_s;
  logic [31:0]         prdata_s;

  assign xfer   = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign idx_ok = ({1'b0, idx_q} < SLV_CNT);

  generate
    if (NUM_SLV > 1) begin : g_idx
      assign idx_in = HADDR[SLV_LSB +: IDX_W];
    end else begin : g_idx1
      assign idx_in = '0;
    end
  endgenerate

  ahb_apb4_strb u_strb (
    .hsize_i  (HSIZE),
    .haddr_i  (HADDR[1:0]),
    .hwrite_i (HWRITE),
    .pstrb_o  (strb_in)
  );

  always_comb begin
    pready_s  = 1'b0;
    pslverr_s = 1'b0;
    prdata_s  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (int'(idx_q) == i) begin
        pready_s  = PREADY[i];
        pslverr_s = PSLVERR[i];
        prdata_s  = PRDATA[32*i +: 32];
      end
    end
  end

  // Bad slave index skips the APB phases entirely and goes straight to ERROR.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:  if (xfer) state_d = ST_WAIT;
      ST_WAIT: begin
        if (!idx_ok)     state_d = ST_ERR1;
        else if (PCLKEN) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (PCLKEN) begin
          state_d = ST_ACCESS;
          cnt_d   = '0;
        end
      end
      ST_ACCESS: begin
        if (PCLKEN) begin
          if (pready_s)                              state_d = pslverr_s ? ST_ERR1 : ST_IDLE;
          else if (TIMEOUT > 0 && cnt_q == TO_LAST)  state_d = ST_ERR1;
          else                                       cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_ERR1:  state_d = ST_ERR2;
      ST_ERR2:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they switch with it.
  always_comb begin
    hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
    hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    penable_d   = (state_d == ST_ACCESS);
    sel_on      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    psel_d      = '0;
    for (int i = 0; i < NUM_SLV; i++) psel_d[i] = sel_on && (int'(idx_q) == i);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      hrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      if (state_q == ST_IDLE && xfer) begin
        idx_q    <= idx_in;
        paddr_q  <= HADDR;
        pwrite_q <= HWRITE;
        pstrb_q  <= strb_in;
        pprot_q  <= apb_prot(HPROT);
      end
      if (state_q == ST_WAIT) pwdata_q <= HWDATA;
      if (state_q == ST_ACCESS && PCLKEN && pready_s && !pslverr_s && !pwrite_q)
        hrdata_q <= prdata_s;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign PPROT     = pprot_q;

endmodule

// File: tb/tb_ahb_apb4_bridge.sv
// Directed plus randomized transfers through the bridge (3 slaves, timeout 4),
// checked against a transaction-level expectation of each APB/AHB outcome.
module tb_ahb_apb4_bridge;

  localparam int NS = 3;
  localparam int TO = 4;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        PCLKEN;
  logic [NS-1:0] PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic [NS-1:0] PREADY;
  logic [NS-1:0] PSLVERR;
  logic [NS*32-1:0] PRDATA;

  int n_err = 0;
  int n_chk = 0;
  int per = 1;
  int ph = 0;
  logic [31:0] last_rd = '0;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahb_apb4_bridge #(.ADDR_W(32), .NUM_SLV(NS), .SLV_LSB(12), .TIMEOUT(TO)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .PCLKEN(PCLKEN),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PPROT(PPROT), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // PCLKEN for the coming edge plus random don't-care slave inputs.
  task automatic bg();
    PCLKEN  = (ph == 0);
    ph      = (ph + 1) % per;
    PREADY  = 3'($urandom);
    PSLVERR = 3'($urandom);
    PRDATA  = {$urandom, $urandom, $urandom};
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      HSEL = 1'b0; HTRANS = 2'b00; bg();
      @(negedge HCLK);
      chk("idle_state", {HREADYOUT, HRESP, PSEL, PENABLE}, {1'b1, 1'b0, 3'b000, 1'b0});
    end
  endtask

  task automatic nop(input logic [1:0] tr);
    HSEL = 1'b1; HTRANS = tr; HADDR = $urandom; HWRITE = 1'($urandom); bg();
    @(negedge HCLK);
    chk("nop_zero_wait", {HREADYOUT, HRESP, PSEL, PENABLE}, {1'b1, 1'b0, 3'b000, 1'b0});
  endtask

  task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] sz,
                         input logic [3:0] prot, input logic [31:0] wdata, input int nwait,
                         input logic slverr, input logic [31:0] rdata);
    int idx, nb, off, acc, low, cyc, exp_acc, exp_low;
    logic [3:0] strb;
    logic [2:0] pp, onehot;
    logic valid, exp_err, done, seen, rdy, pc_edge, prev_rdy, prev_resp;
    logic [1:0] pse, pse_prev;
    idx = int'(addr[13:12]);
    nb  = 1 << sz;
    off = int'(addr[1:0]) / nb * nb;
    for (int b = 0; b < 4; b++) strb[b] = wr && (b >= off) && (b < off + nb);
    pp      = {~prot[0], 1'b1, prot[1]};
    valid   = idx < NS;
    onehot  = valid ? 3'(1 << idx) : 3'b000;
    exp_err = !valid || slverr || (nwait >= TO);
    exp_acc = !valid ? 0 : ((nwait < TO) ? nwait + 1 : TO);
    exp_low = !valid ? 2 : ((nwait >= TO) ? 3 + TO : 3 + nwait + (slverr ? 1 : 0));
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = sz; HPROT = prot;
    HWDATA = $urandom;
    pse_prev = {|PSEL, PENABLE};
    bg();
    done = 1'b0; seen = 1'b0; cyc = 0; low = 0; acc = 0; prev_rdy = 1'b1; prev_resp = 1'b0;
    while (!done && cyc < 300) begin
      pc_edge = PCLKEN;
      @(negedge HCLK);
      cyc++;
      HSEL = 1'($urandom); HTRANS = 2'b00; HWDATA = wdata;
      pse = {|PSEL, PENABLE};
      if (pse != pse_prev) chk("apb_change_on_pclken", pc_edge, 1'b1);
      if (pse == 2'b10 && pse_prev == 2'b00) begin
        seen = 1'b1;
        chk("psel", PSEL, onehot);
        chk("paddr", PADDR, addr);
        chk("pwrite", PWRITE, wr);
        chk("pstrb", PSTRB, strb);
        chk("pprot", PPROT, pp);
        if (wr) chk("pwdata", PWDATA, wdata);
      end
      if (HREADYOUT) begin
        done = 1'b1;
        chk("hresp", HRESP, exp_err);
        chk("resp_prev_cycle", {prev_rdy, prev_resp}, exp_err ? 2'b01 : 2'b00);
        if (!exp_err && !wr) last_rd = rdata;
        chk("hrdata", HRDATA, last_rd);
        chk("access_cycles", acc, exp_acc);
        chk("psel_seen", seen, valid);
        chk("apb_released", {PSEL, PENABLE}, 4'b0000);
        if (per == 1) chk("wait_cycles", low, exp_low);
      end else begin
        low++;
        bg();
        if (pse == 2'b11 && PCLKEN) begin
          rdy = (acc >= nwait);
          acc++;
          PREADY  = rdy ? onehot : ~onehot;
          PSLVERR = rdy ? (slverr ? onehot : ~onehot) : 3'($urandom);
          PRDATA  = {3{~rdata}};
          PRDATA[32*idx +: 32] = rdata;
        end
      end
      prev_rdy = HREADYOUT; prev_resp = HRESP; pse_prev = pse;
    end
    chk("xfer_completed", done, 1'b1);
    if (done && exp_err) begin
      // ERR2 cycle: master cancels; a transfer seen here must be dropped
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_0000; HWRITE = 1'b0; bg();
      @(negedge HCLK);
      chk("err2_ignore", {HREADYOUT, HRESP, PSEL, PENABLE}, {1'b1, 1'b0, 3'b000, 1'b0});
      HSEL = 1'b0; HTRANS = 2'b00;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0] sz;
    int idx, n;
    logic found;
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0;
    HPROT = 4'h0; HWDATA = '0; PCLKEN = 1'b1; PREADY = '0; PSLVERR = '0; PRDATA = '0;
    repeat (2) @(negedge HCLK);
    chk("rst_ctrl", {HREADYOUT, HRESP, PSEL, PENABLE, PWRITE, PSTRB, PPROT},
        {1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 4'h0, 3'b000});
    chk("rst_data", {PADDR, PWDATA, HRDATA}, 96'h0);
    HRESET = 1'b0;
    idle(2);
    nop(2'b00);
    nop(2'b01);

    per = 1; ph = 0;
    do_xfer(32'h0000_2004, 1'b1, 3'd2, 4'h3, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
    per = 3; ph = 0;
    do_xfer(32'h0000_1000, 1'b0, 3'd2, 4'h1, 32'h0, 2, 1'b0, 32'h1234_5678);
    per = 1; ph = 0;
    do_xfer(32'h0000_0008, 1'b1, 3'd2, 4'h0, 32'h5555_AAAA, 0, 1'b1, 32'h0);
    do_xfer(32'h0000_3000, 1'b1, 3'd2, 4'h2, 32'h0BAD_0BAD, 0, 1'b0, 32'h0);
    do_xfer(32'h0000_2000, 1'b0, 3'd2, 4'h3, 32'h0, 1000, 1'b0, 32'hFFFF_0000);
    do_xfer(32'h0000_1001, 1'b1, 3'd0, 4'h1, 32'h0000_AB00, 0, 1'b0, 32'h0);
    do_xfer(32'h0000_1003, 1'b1, 3'd0, 4'h1, 32'hCD00_0000, 0, 1'b0, 32'h0);
    do_xfer(32'h0000_0002, 1'b1, 3'd1, 4'h2, 32'h1357_0000, 1, 1'b0, 32'h0);

    // Reset while the APB access is outstanding
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_0010; HWRITE = 1'b1; HSIZE = 3'd2;
    HPROT = 4'h3; HWDATA = 32'hCAFE_F00D; bg(); PREADY = '0;
    n = 0; found = 1'b0;
    while (!found && n < 20) begin
      @(negedge HCLK);
      n++; HSEL = 1'b0; HTRANS = 2'b00;
      if (PSEL != 0 && PENABLE) found = 1'b1;
      else begin bg(); PREADY = '0; end
    end
    chk("rst_reach_access", found, 1'b1);
    HRESET = 1'b1;
    #1;
    chk("rst_mid_ctrl", {HREADYOUT, HRESP, PSEL, PENABLE, PWRITE, PSTRB, PPROT},
        {1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 4'h0, 3'b000});
    chk("rst_mid_data", {PADDR, PWDATA, HRDATA}, 96'h0);
    last_rd = '0;
    @(negedge HCLK);
    HRESET = 1'b0; bg(); PREADY = '1; PSLVERR = '1;
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      chk("post_rst_quiet", {HREADYOUT, HRESP, PSEL, PENABLE}, {1'b1, 1'b0, 3'b000, 1'b0});
      if (k < 2) begin bg(); PREADY = '1; PSLVERR = '1; end
    end

    for (int t = 0; t < 40; t++) begin
      per = $urandom_range(1, 3); ph = 0;
      n   = $urandom_range(0, 7);
      idx = (n < 7) ? n % 3 : 3;
      sz  = 3'($urandom_range(0, 2));
      a = $urandom;
      a[13:12] = 2'(idx);
      if (sz == 3'd1) a[0] = 1'b0;
      if (sz == 3'd2) a[1:0] = 2'b00;
      do_xfer(a, 1'($urandom), sz, 4'($urandom), $urandom, $urandom_range(0, 5),
              ($urandom_range(0, 5) == 0), $urandom);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
